wb_slave_mem_ws: RTL and testbench
==================================

Name: wb_slave_mem_ws

Overview:
- Synthesizable Wishbone classic slave with an internal word-addressed RAM and a fixed number of wait states.
- Sits directly downstream of the testbench Wishbone master: it consumes cyc/stb/we/adr/sel/dat and returns ack/err/dat.
- Used as the memory target in the wrc_core main_tb, and as a reference slave for master timing checks such as latency, stall and abort.

Parameters:
g_data_width, 32, data bus width; must be a multiple of 8
g_addr_width, 32, word-address bus width
g_mem_words, 256, RAM depth in words; must be a power of two, at least 2
g_wait_states, 1, extra cycles before ack/err (0..15)

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
cyc_i  in  1  bus cycle valid
stb_i  in  1  strobe
we_i  in  1  1 = write, 0 = read
adr_i  in  g_addr_width  word address
sel_i  in  g_data_width/8  byte-lane enables; bit i covers dat bits [8i+7:8i]
dat_i  in  g_data_width  write data
dat_o  out  g_data_width  read data; valid only while ack_o=1
ack_o  out  1  normal termination, one-cycle pulse
err_o  out  1  error termination, one-cycle pulse
stall_o  out  1  1 = request will not be sampled
xfer_cnt_o  out  32  count of terminated transfers (ack or err)

Behaviour:
- Clock and reset: single clock clk_i; reset rst_n_i is asynchronous and active-low.
- Reset values: ack_o=0, err_o=0, stall_o=0, dat_o=0, xfer_cnt_o=0, FSM=IDLE.
  - RAM contents are not reset.
  - Reset asserted mid-transfer: return to IDLE immediately, discard the pending write, emit no ack/err.
- FSM states: IDLE, WAIT, TERM.
- IDLE: stall_o=0.
  - On a rising edge with cyc_i=1 and stb_i=1: latch adr, we, sel, dat and set stall_o=1.
  - Next state is TERM if g_wait_states=0; otherwise WAIT with wait counter = g_wait_states-1.
- WAIT: stall_o=1.
  - Counter decrements each cycle; at 0, go to TERM.
  - cyc_i=0 sampled in WAIT: abort to IDLE. No RAM write, no ack/err, counter not incremented.
- TERM lasts one cycle:
  - In range (latched adr < g_mem_words): ack_o=1.
    - Read: dat_o = RAM[adr] as read before any write in this transfer.
    - Write: on the edge entering TERM, the RAM is updated only on lanes with sel=1; other lanes are unchanged.
  - Out of range: err_o=1, dat_o=0, no write.
  - Always: xfer_cnt_o increments by 1 on the edge entering TERM and wraps from 2^32-1 to 0.
  - Next state is IDLE; stall_o=0 is visible in the cycle after TERM.
- Latency: ack/err is asserted g_wait_states+1 cycles after the sampling edge. Back-to-back transfers are separated by at least one IDLE cycle.
- stb_i=0 with cyc_i=1 in IDLE: no action.
- stb_i changes in WAIT: ignored, because the request is already latched.
- ack_o and err_o are never both 1.
- ack_o/err_o never rise outside TERM; dat_o returns to 0 when ack_o falls.
- RAM index: only the low log2(g_mem_words) bits index the RAM; the range check uses the full adr.
- sel_i=0 on a write: ack returned, RAM unchanged.

Decomposition:
- Shared package wb_slave_pkg holds:
  - the typedef of the FSM state enum (IDLE/WAIT/TERM);
  - a function computing log2 of g_mem_words;
  - the constant c_wb_max_wait_states = 15.
- Natural sub-module: generic_spram_be, a single-port byte-enable RAM with a registered read.
  - Parameters: depth and width.
  - Ports: clk_i, we_i, be_i, addr_i, d_i, q_o.
- The FSM, counters and the range check stay in the top level.

Test Plan:
- Reset: hold rst_n_i=0 for 5 cycles with cyc_i=stb_i=1 -> all outputs 0 and no ack.
- Release reset, g_wait_states=1: write32 addr 0x10 data 0xDEADBEEF, then read32 addr 0x10 -> read returns 0xDEADBEEF.
  - ack arrives 2 cycles after each sampling edge.
  - xfer_cnt_o=2.
- Byte lanes: write 0x11223344 with sel=1111, then write 0xAABBCCDD with sel=0101 at the same word -> readback is 0x11BB33DD.
- Out of range: read at adr=256 with g_mem_words=256 -> err_o=1 for one cycle, ack_o stays 0, dat_o=0.
  - A following write to adr=300 leaves RAM[44] unchanged.
- Abort: g_wait_states=4; start a write to adr 5, drop cyc_i after 2 cycles -> no ack/err, RAM[5] unchanged, xfer_cnt_o unchanged.
  - The next read completes normally.
- Mid-transfer reset and zero-wait latency: assert rst_n_i asynchronously during WAIT -> outputs clear in the same cycle, before the next edge, and the FSM is in IDLE.
  - With g_wait_states=0: ack arrives 1 cycle after sampling.
  - Counter wrap: preload or force the count to 0xFFFFFFFF, then one transfer -> xfer_cnt_o reads 0.

Source files
------------

// File: rtl/wb_slave_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : wb_slave_pkg                                                      |
// | Brief  : Shared types and helpers for the wait-state Wishbone memory slave |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package wb_slave_pkg;

    localparam int c_wb_max_wait_states = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        TERM = 2'd2
    } wb_state_t;

    // Ceiling log2; callers guarantee n >= 2 so the result is at least 1.
    function automatic int f_log2(input int unsigned n);
        int r;
        r = 0;
        for (longint unsigned v = 1; v < longint'(n); v = v << 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_slave_mem_ws_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : wb_slave_mem_ws_if                                                |
// | Brief  : Wishbone classic bus bundle with master and slave views           |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
interface wb_slave_mem_ws_if #(
    parameter int g_data_width = 32,
    parameter int g_addr_width = 32
);
    // Signal names follow the slave's point of view.
    logic                      cyc_i;
    logic                      stb_i;
    logic                      we_i;
    logic [g_addr_width-1:0]   adr_i;
    logic [g_data_width/8-1:0] sel_i;
    logic [g_data_width-1:0]   dat_i;
    logic [g_data_width-1:0]   dat_o;
    logic                      ack_o;
    logic                      err_o;
    logic                      stall_o;

    modport master (
        output cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
        input  dat_o, ack_o, err_o, stall_o
    );

    modport slave (
        input  cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
        output dat_o, ack_o, err_o, stall_o
    );

endinterface
`default_nettype wire

// File: rtl/wb_slave_mem_ws_spram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : generic_spram_be                                                  |
// | Brief  : Single-port RAM with byte-lane write enables and registered read  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module generic_spram_be
    import wb_slave_pkg::*;
#(
    parameter int g_depth = 256,
    parameter int g_width = 32
) (
    input  logic                   clk_i,
    input  logic                   we_i,
    input  logic [g_width/8-1:0]   be_i,
    input  logic [f_log2(g_depth)-1:0] addr_i,
    input  logic [g_width-1:0]     d_i,
    output logic [g_width-1:0]     q_o
);

    localparam int c_nbytes = g_width / 8;

    logic [g_width-1:0] r_mem [g_depth];

    // Read returns the pre-write word when read and write hit the same address.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < c_nbytes; i++) begin
                if (be_i[i]) begin
                    r_mem[addr_i][8*i +: 8] <= d_i[8*i +: 8];
                end
            end
        end
        q_o <= r_mem[addr_i];
    end

endmodule
`default_nettype wire

// File: rtl/wb_slave_mem_ws.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : wb_slave_mem_ws                                                   |
// | Brief  : Wishbone classic memory slave with fixed wait states and counter  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module wb_slave_mem_ws
    import wb_slave_pkg::*;
#(
    parameter int g_data_width  = 32,
    parameter int g_addr_width  = 32,
    parameter int g_mem_words   = 256,
    parameter int g_wait_states = 1
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    wb_slave_mem_ws_if.slave    wb,
    output logic [31:0]         xfer_cnt_o
);

    localparam int                      c_idx_w     = f_log2(g_mem_words);
    localparam int                      c_sel_w     = g_data_width / 8;
    localparam logic                    c_zero_ws   = (g_wait_states == 0);
    localparam logic [3:0]              c_wait_init = (g_wait_states > 0) ? 4'(g_wait_states - 1) : 4'd0;
    localparam logic [g_addr_width:0]   c_mem_limit = (g_addr_width + 1)'(g_mem_words);

    wb_state_t                  r_state;
    logic [3:0]                 r_wait_cnt;
    logic [g_addr_width-1:0]    r_adr;
    logic                       r_we;
    logic [c_sel_w-1:0]         r_sel;
    logic [g_data_width-1:0]    r_dat;
    logic                       r_ack;
    logic                       r_err;
    logic                       r_stall;
    logic                       r_rd_valid;
    logic [31:0]                r_xfer_cnt;

    logic                       w_idle;
    logic                       w_start;
    logic                       w_enter_term;
    logic                       w_in_range;
    logic                       w_ram_we;
    logic [g_addr_width-1:0]    w_req_adr;
    logic                       w_req_we;
    logic [c_sel_w-1:0]         w_req_sel;
    logic [g_data_width-1:0]    w_req_dat;
    logic [g_data_width-1:0]    w_ram_q;

    // With zero wait states the request goes to TERM on its sampling edge, so
    // the live bus is used in IDLE and the latched copy everywhere else.
    assign w_idle    = (r_state == IDLE);
    assign w_start   = w_idle & wb.cyc_i & wb.stb_i;
    assign w_req_adr = w_idle ? wb.adr_i : r_adr;
    assign w_req_we  = w_idle ? wb.we_i  : r_we;
    assign w_req_sel = w_idle ? wb.sel_i : r_sel;
    assign w_req_dat = w_idle ? wb.dat_i : r_dat;

    assign w_enter_term = (w_start & c_zero_ws)
                        | ((r_state == WAIT) & wb.cyc_i & (r_wait_cnt == 4'd0));
    assign w_in_range   = ({1'b0, w_req_adr} < c_mem_limit);
    assign w_ram_we     = w_enter_term & w_req_we & w_in_range;

    generic_spram_be #(
        .g_depth (g_mem_words),
        .g_width (g_data_width)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (w_ram_we),
        .be_i    (w_req_sel),
        .addr_i  (w_req_adr[c_idx_w-1:0]),
        .d_i     (w_req_dat),
        .q_o     (w_ram_q)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= IDLE;
            r_wait_cnt <= 4'd0;
            r_adr      <= '0;
            r_we       <= 1'b0;
            r_sel      <= '0;
            r_dat      <= '0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_stall    <= 1'b0;
            r_rd_valid <= 1'b0;
            r_xfer_cnt <= 32'd0;
        end else begin
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_rd_valid <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_adr   <= wb.adr_i;
                        r_we    <= wb.we_i;
                        r_sel   <= wb.sel_i;
                        r_dat   <= wb.dat_i;
                        r_stall <= 1'b1;
                        if (c_zero_ws) begin
                            r_state <= TERM;
                        end else begin
                            r_state    <= WAIT;
                            r_wait_cnt <= c_wait_init;
                        end
                    end
                end
                WAIT: begin
                    if (!wb.cyc_i) begin
                        r_state <= IDLE;
                        r_stall <= 1'b0;
                    end else if (r_wait_cnt == 4'd0) begin
                        r_state <= TERM;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                TERM: begin
                    r_state <= IDLE;
                    r_stall <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_stall <= 1'b0;
                end
            endcase

            if (w_enter_term) begin
                r_ack      <= w_in_range;
                r_err      <= ~w_in_range;
                r_rd_valid <= w_in_range & ~w_req_we;
                r_xfer_cnt <= r_xfer_cnt + 32'd1;
            end
        end
    end

    assign wb.ack_o   = r_ack;
    assign wb.err_o   = r_err;
    assign wb.stall_o = r_stall;
    assign wb.dat_o   = r_rd_valid ? w_ram_q : '0;
    assign xfer_cnt_o = r_xfer_cnt;

endmodule
`default_nettype wire

// File: tb/tb_wb_slave_mem_ws.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_wb_slave_mem_ws                                                |
// | Brief  : Directed bench for wb_slave_mem_ws with 1, 4 and 0 wait states    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_wb_slave_mem_ws;
    import wb_slave_pkg::*;

    logic        clk;
    logic        rst_n [3];
    logic        cyc   [3];
    logic        stb   [3];
    logic        we    [3];
    logic [31:0] adr   [3];
    logic [31:0] wdat  [3];
    logic [3:0]  sel   [3];
    logic        ack_w   [3];
    logic        err_w   [3];
    logic        stall_w [3];
    logic [31:0] rdat_w  [3];
    logic [31:0] cnt_w   [3];

    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wb_slave_mem_ws_if #(.g_data_width(32), .g_addr_width(32)) bus0 ();
    wb_slave_mem_ws_if #(.g_data_width(32), .g_addr_width(32)) bus1 ();
    wb_slave_mem_ws_if #(.g_data_width(32), .g_addr_width(32)) bus2 ();

    assign bus0.cyc_i = cyc[0]; assign bus0.stb_i = stb[0]; assign bus0.we_i = we[0];
    assign bus0.adr_i = adr[0]; assign bus0.dat_i = wdat[0]; assign bus0.sel_i = sel[0];
    assign bus1.cyc_i = cyc[1]; assign bus1.stb_i = stb[1]; assign bus1.we_i = we[1];
    assign bus1.adr_i = adr[1]; assign bus1.dat_i = wdat[1]; assign bus1.sel_i = sel[1];
    assign bus2.cyc_i = cyc[2]; assign bus2.stb_i = stb[2]; assign bus2.we_i = we[2];
    assign bus2.adr_i = adr[2]; assign bus2.dat_i = wdat[2]; assign bus2.sel_i = sel[2];

    assign ack_w[0] = bus0.ack_o; assign err_w[0] = bus0.err_o;
    assign stall_w[0] = bus0.stall_o; assign rdat_w[0] = bus0.dat_o;
    assign ack_w[1] = bus1.ack_o; assign err_w[1] = bus1.err_o;
    assign stall_w[1] = bus1.stall_o; assign rdat_w[1] = bus1.dat_o;
    assign ack_w[2] = bus2.ack_o; assign err_w[2] = bus2.err_o;
    assign stall_w[2] = bus2.stall_o; assign rdat_w[2] = bus2.dat_o;

    wb_slave_mem_ws #(.g_data_width(32), .g_addr_width(32), .g_mem_words(256), .g_wait_states(1))
        dut0 (.clk_i(clk), .rst_n_i(rst_n[0]), .wb(bus0.slave), .xfer_cnt_o(cnt_w[0]));
    wb_slave_mem_ws #(.g_data_width(32), .g_addr_width(32), .g_mem_words(256), .g_wait_states(4))
        dut1 (.clk_i(clk), .rst_n_i(rst_n[1]), .wb(bus1.slave), .xfer_cnt_o(cnt_w[1]));
    wb_slave_mem_ws #(.g_data_width(32), .g_addr_width(32), .g_mem_words(256), .g_wait_states(0))
        dut2 (.clk_i(clk), .rst_n_i(rst_n[2]), .wb(bus2.slave), .xfer_cnt_o(cnt_w[2]));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // One classic transfer; reports data and latency at the termination strobe,
    // then whether the strobe lasted one cycle with dat_o and stall_o back at 0.
    task automatic bus_xfer(input int d, input bit w, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] s,
                            output logic [31:0] rd, output int lat,
                            output bit got_ack, output bit got_err, output bit pulse_ok);
        @(negedge clk);
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; wdat[d] = wd; sel[d] = s;
        @(posedge clk);
        #1 stb[d] = 1'b0;
        lat = 0; got_ack = 1'b0; got_err = 1'b0; rd = '0; pulse_ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (ack_w[d] || err_w[d]) begin
                got_ack = ack_w[d]; got_err = err_w[d]; rd = rdat_w[d];
                break;
            end
        end
        cyc[d] = 1'b0; we[d] = 1'b0;
        @(negedge clk);
        pulse_ok = !ack_w[d] && !err_w[d] && (rdat_w[d] == 32'd0) && !stall_w[d];
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        bit          a, e, p;
        int          hits;

        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0; cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
            adr[i] = '0; wdat[i] = '0; sel[i] = '0;
        end

        // Reset held with an active request on the bus
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; sel[0] = 4'hF;
        hits = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ack_w[0] || err_w[0]) hits++;
        end
        check_eq("rst_no_term", 32'(hits), 32'd0);
        check_eq("rst_stall", 32'(stall_w[0]), 32'd0);
        check_eq("rst_dat", rdat_w[0], 32'd0);
        check_eq("rst_cnt", cnt_w[0], 32'd0);
        cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

        // One wait state: write then read back
        bus_xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, lat, a, e, p);
        check_eq("wr_ack", 32'(a), 32'd1);
        check_eq("wr_lat", 32'(lat), 32'd2);
        check_eq("wr_pulse", 32'(p), 32'd1);
        bus_xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, lat, a, e, p);
        check_eq("rd_data", rd, 32'hDEADBEEF);
        check_eq("rd_lat", 32'(lat), 32'd2);
        check_eq("rd_pulse", 32'(p), 32'd1);
        check_eq("cnt_after_2", cnt_w[0], 32'd2);

        // Byte-lane merge
        bus_xfer(0, 1'b1, 32'h20, 32'h11223344, 4'b1111, rd, lat, a, e, p);
        bus_xfer(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, lat, a, e, p);
        bus_xfer(0, 1'b0, 32'h20, 32'h0, 4'hF, rd, lat, a, e, p);
        check_eq("lane_data", rd, 32'h11BB33DD);

        // Out of range accesses, including an alias of word 44
        bus_xfer(0, 1'b1, 32'd44, 32'h44440044, 4'hF, rd, lat, a, e, p);
        bus_xfer(0, 1'b0, 32'd256, 32'h0, 4'hF, rd, lat, a, e, p);
        check_eq("oor_err", 32'(e), 32'd1);
        check_eq("oor_ack", 32'(a), 32'd0);
        check_eq("oor_dat", rd, 32'd0);
        check_eq("oor_pulse", 32'(p), 32'd1);
        bus_xfer(0, 1'b1, 32'd300, 32'hFFFFFFFF, 4'hF, rd, lat, a, e, p);
        check_eq("oor_wr_err", 32'(e), 32'd1);
        bus_xfer(0, 1'b0, 32'd44, 32'h0, 4'hF, rd, lat, a, e, p);
        check_eq("alias_kept", rd, 32'h44440044);
        check_eq("cnt_after_9", cnt_w[0], 32'd9);

        // Four wait states: abort during WAIT
        bus_xfer(1, 1'b1, 32'd5, 32'h55555555, 4'hF, rd, lat, a, e, p);
        check_eq("ws4_wr_lat", 32'(lat), 32'd5);
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'd5;
        wdat[1] = 32'h12345678; sel[1] = 4'hF;
        @(posedge clk);
        #1 stb[1] = 1'b0;
        @(negedge clk);
        check_eq("abort_stall", 32'(stall_w[1]), 32'd1);
        @(negedge clk);
        cyc[1] = 1'b0; we[1] = 1'b0;
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack_w[1] || err_w[1]) hits++;
        end
        check_eq("abort_no_term", 32'(hits), 32'd0);
        check_eq("abort_cnt", cnt_w[1], 32'd1);
        check_eq("abort_idle_stall", 32'(stall_w[1]), 32'd0);
        bus_xfer(1, 1'b0, 32'd5, 32'h0, 4'hF, rd, lat, a, e, p);
        check_eq("abort_ram", rd, 32'h55555555);
        check_eq("abort_rd_lat", 32'(lat), 32'd5);
        check_eq("abort_cnt2", cnt_w[1], 32'd2);

        // Asynchronous reset during WAIT
        bus_xfer(1, 1'b1, 32'd6, 32'h06060606, 4'hF, rd, lat, a, e, p);
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'd6;
        wdat[1] = 32'h0BAD0BAD; sel[1] = 4'hF;
        @(posedge clk);
        #1 stb[1] = 1'b0;
        @(negedge clk);
        #2 rst_n[1] = 1'b0;
        #1;
        check_eq("mrst_stall", 32'(stall_w[1]), 32'd0);
        check_eq("mrst_state", 32'(dut1.r_state), 32'(IDLE));
        check_eq("mrst_cnt", cnt_w[1], 32'd0);
        cyc[1] = 1'b0; we[1] = 1'b0;
        @(negedge clk);
        rst_n[1] = 1'b1;
        bus_xfer(1, 1'b0, 32'd6, 32'h0, 4'hF, rd, lat, a, e, p);
        check_eq("mrst_ram", rd, 32'h06060606);
        check_eq("mrst_cnt_after", cnt_w[1], 32'd1);

        // Zero wait states and counter wrap
        bus_xfer(2, 1'b1, 32'd3, 32'hCAFEF00D, 4'hF, rd, lat, a, e, p);
        check_eq("ws0_wr_lat", 32'(lat), 32'd1);
        bus_xfer(2, 1'b0, 32'd3, 32'h0, 4'hF, rd, lat, a, e, p);
        check_eq("ws0_rd_data", rd, 32'hCAFEF00D);
        check_eq("ws0_rd_lat", 32'(lat), 32'd1);
        @(negedge clk);
        force dut2.r_xfer_cnt = 32'hFFFFFFFF;
        #1 release dut2.r_xfer_cnt;
        bus_xfer(2, 1'b0, 32'd3, 32'h0, 4'hF, rd, lat, a, e, p);
        check_eq("cnt_wrap", cnt_w[2], 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
